hacd_decompressor: RTL and testbench
====================================

# hacd_decompressor

Inverse of the HACD page compressor. It reads a compressed page from the read FIFO and writes the reconstructed 64-cacheline (4 KB) page to the write FIFO. The compressed page is one metadata line followed by zero or one 16-line data chunk. The block sits in the HACD comp_decomp datapath next to the compressor and shares its FIFO handshake.

## Interface
- FIFO_PTR_WIDTH, 6, width of read FIFO pointer
- DATA_WIDTH, `HACD_AXI4_DATA_WIDTH (512), cacheline width in bits

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- decomp_start  in  1  level request; sampled only in IDLE
- rdfifo_empty  in  1  read FIFO holds no lines
- rdfifo_rdptr  out  FIFO_PTR_WIDTH  read pointer value to load
- ld_rdfifo_rdptr  out  1  one-cycle pulse that loads rdfifo_rdptr
- rd_req  out  1  one-cycle read request pulse
- rd_data  in  DATA_WIDTH  returned line
- rd_rresp  in  2  response; 0 = OKAY
- rd_valid  in  1  rd_data/rd_rresp valid
- wrfifo_full  in  1  write FIFO almost-full (at least one free slot left when asserted)
- wr_req  out  1  one-cycle write pulse
- wr_data  out  DATA_WIDTH  line to write, valid with wr_req
- decomp_done  out  1  page fully written
- meta_error  out  1  metadata illegal
- bus_error  out  1  nonzero rd_rresp seen
- dbg_state  out  3  current state
- dbg_out_cnt  out  7  lines written so far (0..64)

## Operation
- Metadata line: rd_data[3:0] = zero_chunk_vec. Bit i = 1 means chunk i (output lines 16i..16i+15) is all zero. rd_data[DATA_WIDTH-1:4] is ignored.
- Legal vectors contain at most one 0 bit:
  - 4'hF: all-zero page, no data lines follow.
  - One 0 bit at position k: 16 data lines follow, belonging to chunk k.
- Any other vector is illegal and goes to META_ERR.
- States: IDLE, LOAD_PTR, RD_META, EMIT, RD_LINE, DONE, META_ERR, BUS_ERR.
- IDLE:
  - When decomp_start && !rdfifo_empty: clear out_cnt, drive rdfifo_rdptr=0, pulse ld_rdfifo_rdptr, go to LOAD_PTR.
- LOAD_PTR:
  - Go to RD_META next cycle.
- RD_META:
  - Issue rd_req when !rdfifo_empty and no read is outstanding.
  - On rd_valid with rd_rresp==0: latch the vector, then go to EMIT if legal, else META_ERR.
  - On rd_valid with rd_rresp!=0: go to BUS_ERR.
- EMIT, chunk index = out_cnt[5:4]:
  - Zero chunk: each cycle with !wrfifo_full, write one all-zero line and increment out_cnt.
  - Non-zero chunk: go to RD_LINE.
  - out_cnt==64: go to DONE.
- RD_LINE:
  - Issue rd_req only when !rdfifo_empty && !wrfifo_full && no read is outstanding.
  - On rd_valid with rd_rresp==0: wr_data=rd_data, pulse wr_req, out_cnt+1, return to EMIT.
  - Nonzero rd_rresp: go to BUS_ERR.
- DONE:
  - decomp_done=1; stay while decomp_start=1; go to IDLE when it drops.
- META_ERR / BUS_ERR:
  - Flag held high; the state is sticky until rst_i.
- At most one read outstanding. rd_valid with no outstanding read is ignored.
- decomp_start deasserting mid-page is ignored; the page completes.
- out_cnt is 7 bits and never exceeds 64; no wrap.

## Timing
- All outputs are registered.
- Reset values: rd_req=0, ld_rdfifo_rdptr=0, rdfifo_rdptr=0, wr_req=0, wr_data=0, decomp_done=0, meta_error=0, bus_error=0, dbg_state=IDLE, dbg_out_cnt=0.
- rst_i asserted mid-page aborts the page immediately. The write FIFO is not rolled back.
- rd_req asserts the cycle after its issue condition holds. rd_valid may arrive one or more cycles later.
- wr_req asserts the cycle after the decision. wrfifo_full is sampled in the decision cycle, which is why one slot of slack is required.
- Zero chunks are emitted at one line per cycle with no stalls.
- All-zero page: start to done ≈ 3 + read latency + 64 cycles.
- If rd_valid and wrfifo_full assert in the same cycle in RD_LINE, the write still issues. It is covered by the slack slot.

## Test plan
- All-zero page: metadata 4'hF, wrfifo_full=0 -> 64 wr_req pulses on consecutive cycles, all wr_data=0; decomp_done=1; exactly 1 rd_req.
- Chunk 2 non-zero: metadata 4'hB, data lines 0x100..0x10F -> output lines 0..31 and 48..63 are zero, lines 32..47 equal 0x100..0x10F in order; 17 rd_req total.
- Backpressure: metadata 4'hE with wrfifo_full toggling every 3 cycles -> no wr_req while full except the one already decided; still 64 lines with correct order.
- Illegal metadata 4'h3 -> meta_error=1, no wr_req, state stays META_ERR until rst_i.
- rd_rresp=2 on the 5th data line -> bus_error=1, exactly 4 data lines written (plus any preceding zero chunks), no further rd_req.
- rst_i asserted at out_cnt=20 -> all outputs return to reset values asynchronously. A new decomp_start then decompresses a fresh page correctly.

Source files
------------

// File: rtl/hacd_decompressor.sv
// hacd_decompressor: rebuilds a 64-line page from one metadata line plus
// at most one 16-line data chunk. Lines come from the read FIFO and go out
// to the write FIFO.
module hacd_decompressor #(
  parameter int FIFO_PTR_WIDTH = 6,
  parameter int DATA_WIDTH     = 512
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      decomp_start,
  input  logic                      rdfifo_empty,
  output logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr,
  output logic                      ld_rdfifo_rdptr,
  output logic                      rd_req,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic [1:0]                rd_rresp,
  input  logic                      rd_valid,
  input  logic                      wrfifo_full,
  output logic                      wr_req,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      decomp_done,
  output logic                      meta_error,
  output logic                      bus_error,
  output logic [2:0]                dbg_state,
  output logic [6:0]                dbg_out_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_PTR = 3'd1,
    S_RD_META  = 3'd2,
    S_EMIT     = 3'd3,
    S_RD_LINE  = 3'd4,
    S_DONE     = 3'd5,
    S_META_ERR = 3'd6,
    S_BUS_ERR  = 3'd7
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [6:0]                  r_out_cnt;
  logic [6:0]                  w_cnt_nxt;
  logic [3:0]                  r_vec;
  logic [3:0]                  w_vec_nxt;
  logic                        r_outst;
  logic                        w_outst_nxt;
  logic                        w_accept;
  logic                        r_rd_req;
  logic                        w_rd_req_nxt;
  logic                        r_ld_ptr;
  logic                        w_ld_nxt;
  logic [FIFO_PTR_WIDTH-1:0]   r_rdptr;
  logic                        r_wr_req;
  logic                        w_wr_req_nxt;
  logic [DATA_WIDTH-1:0]       r_wr_data;
  logic [DATA_WIDTH-1:0]       w_wr_data_nxt;
  logic                        r_done;
  logic                        r_meta_err;
  logic                        r_bus_err;

  // A legal zero-chunk vector has at most one chunk carrying data.
  function automatic logic meta_legal(input logic [3:0] v);
    int unsigned zeros;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) zeros++;
    end
    return (zeros <= 1);
  endfunction

  // Only a response to our single outstanding read is consumed; stray valids are dropped.
  assign w_accept = rd_valid && r_outst;

  // Next-state, read/write issue and counter updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_out_cnt;
    w_vec_nxt     = r_vec;
    w_outst_nxt   = r_outst;
    w_rd_req_nxt  = 1'b0;
    w_ld_nxt      = 1'b0;
    w_wr_req_nxt  = 1'b0;
    w_wr_data_nxt = r_wr_data;
    if (w_accept) w_outst_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (decomp_start && !rdfifo_empty) begin
          w_cnt_nxt   = 7'd0;
          w_ld_nxt    = 1'b1;
          w_state_nxt = S_LOAD_PTR;
        end
      end
      S_LOAD_PTR: w_state_nxt = S_RD_META;
      S_RD_META: begin
        if (w_accept) begin
          if (rd_rresp == 2'd0) begin
            w_vec_nxt   = rd_data[3:0];
            w_state_nxt = meta_legal(rd_data[3:0]) ? S_EMIT : S_META_ERR;
          end else begin
            w_state_nxt = S_BUS_ERR;
          end
        end else if (!rdfifo_empty && !r_outst) begin
          w_rd_req_nxt = 1'b1;
          w_outst_nxt  = 1'b1;
        end
      end
      S_EMIT: begin
        if (r_out_cnt == 7'd64) begin
          w_state_nxt = S_DONE;
        end else if (r_vec[r_out_cnt[5:4]]) begin
          if (!wrfifo_full) begin
            w_wr_req_nxt  = 1'b1;
            w_wr_data_nxt = '0;
            w_cnt_nxt     = r_out_cnt + 7'd1;
          end
        end else begin
          w_state_nxt = S_RD_LINE;
        end
      end
      S_RD_LINE: begin
        if (w_accept) begin
          if (rd_rresp == 2'd0) begin
            // The slack slot in the write FIFO absorbs this write even if full just rose.
            w_wr_req_nxt  = 1'b1;
            w_wr_data_nxt = rd_data;
            w_cnt_nxt     = r_out_cnt + 7'd1;
            w_state_nxt   = S_EMIT;
          end else begin
            w_state_nxt = S_BUS_ERR;
          end
        end else if (!rdfifo_empty && !wrfifo_full && !r_outst) begin
          w_rd_req_nxt = 1'b1;
          w_outst_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        if (!decomp_start) w_state_nxt = S_IDLE;
      end
      default: ;
    endcase
  end

  // State and registered outputs; error states are sticky until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_out_cnt  <= 7'd0;
      r_vec      <= 4'd0;
      r_outst    <= 1'b0;
      r_rd_req   <= 1'b0;
      r_ld_ptr   <= 1'b0;
      r_rdptr    <= '0;
      r_wr_req   <= 1'b0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_meta_err <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_out_cnt  <= w_cnt_nxt;
      r_vec      <= w_vec_nxt;
      r_outst    <= w_outst_nxt;
      r_rd_req   <= w_rd_req_nxt;
      r_ld_ptr   <= w_ld_nxt;
      if (w_ld_nxt) r_rdptr <= '0;
      r_wr_req   <= w_wr_req_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_done     <= (w_state_nxt == S_DONE);
      r_meta_err <= (w_state_nxt == S_META_ERR);
      r_bus_err  <= (w_state_nxt == S_BUS_ERR);
    end
  end

  assign rdfifo_rdptr    = r_rdptr;
  assign ld_rdfifo_rdptr = r_ld_ptr;
  assign rd_req          = r_rd_req;
  assign wr_req          = r_wr_req;
  assign wr_data         = r_wr_data;
  assign decomp_done     = r_done;
  assign meta_error      = r_meta_err;
  assign bus_error       = r_bus_err;
  assign dbg_state       = r_state;
  assign dbg_out_cnt     = r_out_cnt;

endmodule

// File: tb/tb_hacd_decompressor.sv
// Bench for hacd_decompressor: random read latency, random/patterned write
// backpressure, and a page-level reference model of the expected output.
module tb_hacd_decompressor;
  localparam int DW = 512;
  localparam int PW = 6;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_DONE = 3'd5, ST_META_ERR = 3'd6, ST_BUS_ERR = 3'd7;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          decomp_start;
  logic          rdfifo_empty = 1'b0;
  logic [PW-1:0] rdfifo_rdptr;
  logic          ld_rdfifo_rdptr;
  logic          rd_req;
  logic [DW-1:0] rd_data = '0;
  logic [1:0]    rd_rresp = 2'd0;
  logic          rd_valid = 1'b0;
  logic          wrfifo_full = 1'b0;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          decomp_done, meta_error, bus_error;
  logic [2:0]    dbg_state;
  logic [6:0]    dbg_out_cnt;

  hacd_decompressor #(.FIFO_PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .decomp_start(decomp_start), .rdfifo_empty(rdfifo_empty),
    .rdfifo_rdptr(rdfifo_rdptr), .ld_rdfifo_rdptr(ld_rdfifo_rdptr), .rd_req(rd_req),
    .rd_data(rd_data), .rd_rresp(rd_rresp), .rd_valid(rd_valid), .wrfifo_full(wrfifo_full),
    .wr_req(wr_req), .wr_data(wr_data), .decomp_done(decomp_done), .meta_error(meta_error),
    .bus_error(bus_error), .dbg_state(dbg_state), .dbg_out_cnt(dbg_out_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Page source: index 0 is the metadata line, 1..16 the data lines.
  logic [DW-1:0] page_line [17];
  logic [1:0]    page_resp [17];
  int epoch = 0;
  int full_mode = 0;
  bit rand_empty = 1'b0;

  // Responder / monitor state (owned by the negedge process).
  int cyc = 0, rd_idx = 0, lat = 0, last_epoch = 0;
  int rd_cnt = 0, dbl_cnt = 0, ld_cnt = 0, ld_bad = 0;
  bit pend = 1'b0, cur_full = 1'b0;
  logic [DW-1:0] wr_q [$];
  bit            wr_full_q [$];
  int            wr_cyc_q [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Read FIFO responder, write FIFO monitor and input randomisation.
  always @(negedge clk) begin
    cyc++;
    if (epoch != last_epoch || rst_i) begin
      last_epoch = epoch;
      rd_idx = 0;
      pend = 1'b0;
    end
    if (wr_req) begin
      wr_q.push_back(wr_data);
      wr_full_q.push_back(cur_full);
      wr_cyc_q.push_back(cyc);
    end
    if (ld_rdfifo_rdptr) begin
      ld_cnt++;
      if (rdfifo_rdptr != '0) ld_bad++;
    end
    rd_valid = 1'b0;
    if (pend) begin
      if (lat == 0) begin
        rd_valid = 1'b1;
        rd_data  = (rd_idx < 17) ? page_line[rd_idx] : '0;
        rd_rresp = (rd_idx < 17) ? page_resp[rd_idx] : 2'd0;
        rd_idx++;
        pend = 1'b0;
      end else begin
        lat--;
      end
    end
    if (rd_req) begin
      rd_cnt++;
      if (pend) dbl_cnt++;
      pend = 1'b1;
      lat = $urandom_range(0, 2);
    end
    case (full_mode)
      0:       wrfifo_full = 1'b0;
      1:       wrfifo_full = ((cyc / 3) % 2) == 1;
      default: wrfifo_full = ($urandom_range(0, 2) == 0);
    endcase
    cur_full = wrfifo_full;
    rdfifo_empty = rand_empty ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_ld"}, ld_rdfifo_rdptr, 0);
    chk({tag, "_rdptr"}, rdfifo_rdptr, 0);
    chk({tag, "_wr_req"}, wr_req, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_done"}, decomp_done, 0);
    chk({tag, "_meta"}, meta_error, 0);
    chk({tag, "_bus"}, bus_error, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
    chk({tag, "_cnt"}, dbg_out_cnt, 0);
  endtask

  task automatic load_page(input logic [3:0] vec, input int kind, input int err_line);
    epoch++;
    page_line[0] = rand_line();
    page_line[0][3:0] = vec;
    page_resp[0] = 2'd0;
    for (int i = 1; i < 17; i++) begin
      page_line[i] = (kind == 1) ? DW'(32'h100 + i - 1) : rand_line();
      page_resp[i] = (i == err_line) ? 2'd2 : 2'd0;
    end
  endtask

  task automatic run_page(input string name, input logic [3:0] vec, input int kind,
                          input int err_line, input int fmode, input bit remp);
    int wb, rb, db, lb, cnt, nz, k, exp_wr, exp_rd, nwr, viol;
    bit legal;
    logic [DW-1:0] exp_line;
    full_mode = fmode;
    rand_empty = remp;
    load_page(vec, kind, err_line);
    wb = wr_q.size(); rb = rd_cnt; db = dbl_cnt; lb = ld_cnt;
    decomp_start = 1'b1;
    cnt = 0;
    while (!(decomp_done || meta_error || bus_error) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    chk({name, "_finished"}, cnt < 3000, 1);
    repeat (6) @(negedge clk);
    // Reference model from the zero-chunk vector.
    nz = 0; k = 0;
    for (int i = 0; i < 4; i++) if (!vec[i]) begin nz++; k = i; end
    legal = (nz <= 1);
    if (!legal) begin
      exp_wr = 0; exp_rd = 1;
    end else if (err_line > 0) begin
      exp_wr = 16 * k + err_line - 1; exp_rd = 1 + err_line;
    end else begin
      exp_wr = 64; exp_rd = 1 + ((nz == 1) ? 16 : 0);
    end
    nwr = wr_q.size() - wb;
    chk({name, "_done"}, decomp_done, legal && err_line == 0);
    chk({name, "_meta_err"}, meta_error, !legal);
    chk({name, "_bus_err"}, bus_error, legal && err_line > 0);
    chk({name, "_n_writes"}, nwr, exp_wr);
    chk({name, "_n_reads"}, rd_cnt - rb, exp_rd);
    chk({name, "_dbl_issue"}, dbl_cnt - db, 0);
    chk({name, "_ld_pulses"}, ld_cnt - lb, 1);
    chk({name, "_ld_ptr"}, ld_bad, 0);
    viol = 0;
    for (int i = 0; i < nwr && i < exp_wr; i++) begin
      exp_line = vec[i/16] ? '0 : page_line[1 + (i % 16)];
      chk($sformatf("%s_line%0d", name, i), wr_q[wb + i], exp_line);
      if (vec[i/16] && wr_full_q[wb + i]) viol++;
    end
    chk({name, "_zero_wr_while_full"}, viol, 0);
    if (legal && err_line == 0) begin
      chk({name, "_cnt64"}, dbg_out_cnt, 64);
      chk({name, "_st_done"}, dbg_state, ST_DONE);
      if (vec == 4'hF && fmode == 0 && nwr == 64)
        chk({name, "_back_to_back"}, wr_cyc_q[wb + 63] - wr_cyc_q[wb], 63);
      decomp_start = 1'b0;
      repeat (2) @(negedge clk);
      chk({name, "_done_clr"}, decomp_done, 0);
      chk({name, "_st_idle"}, dbg_state, ST_IDLE);
    end else begin
      chk({name, "_st_err"}, dbg_state, legal ? ST_BUS_ERR : ST_META_ERR);
      decomp_start = 1'b0;
      repeat (3) @(negedge clk);
      chk({name, "_err_sticky"}, dbg_state, legal ? ST_BUS_ERR : ST_META_ERR);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      chk({name, "_err_cleared"}, dbg_state, ST_IDLE);
    end
  endtask

  initial begin
    int cnt, r;
    logic [3:0] v;
    rst_i = 1'b1;
    decomp_start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    rst_i = 1'b0;
    @(negedge clk);
    chk_reset_vals("after_reset");

    run_page("all_zero", 4'hF, 0, 0, 0, 1'b0);
    run_page("chunk2", 4'hB, 1, 0, 0, 1'b0);
    run_page("backpress", 4'hE, 0, 0, 1, 1'b0);
    run_page("illegal3", 4'h3, 0, 0, 0, 1'b0);
    run_page("illegal0", 4'h0, 0, 0, 2, 1'b1);
    run_page("buserr", 4'hD, 0, 5, 2, 1'b0);

    // Asynchronous reset in the middle of a page.
    full_mode = 0;
    rand_empty = 1'b0;
    load_page(4'hE, 0, 0);
    decomp_start = 1'b1;
    cnt = 0;
    while (dbg_out_cnt < 7'd20 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("midreset_reached20", dbg_out_cnt, 20);
    #2 rst_i = 1'b1;
    #1 chk_reset_vals("midreset_async");
    decomp_start = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    run_page("after_midreset", 4'h7, 0, 0, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      r = $urandom_range(0, 4);
      v = 4'hF ^ 4'(4'b0001 << r);
      run_page($sformatf("rand%0d", t), v, 0, 0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
